// File: rtl/y_pkg.sv
// ---------------------------------------------------------------------------
// y_pkg : shared width constant and word type for the y_adder datapath
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package y_pkg;
  localparam int Y_WIDTH = 32;
  typedef logic [Y_WIDTH-1:0] y_word_t;
endpackage

`default_nettype wire

// File: rtl/y_adder_fa.sv
// ---------------------------------------------------------------------------
// yAdder1 : 1-bit full adder built from gate primitives
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module yAdder1 (
  output wire z,
  output wire cout,
  input  wire a,
  input  wire b,
  input  wire cin
);
  wire w_axb;
  wire w_ab;
  wire w_ac;
  wire w_bc;

  xor u_x0 (w_axb, a, b);
  xor u_x1 (z, w_axb, cin);
  and u_a0 (w_ab, a, b);
  and u_a1 (w_ac, a, cin);
  and u_a2 (w_bc, b, cin);
  or  u_o0 (cout, w_ab, w_ac, w_bc);
endmodule

`default_nettype wire

// File: rtl/y_adder.sv
// ---------------------------------------------------------------------------
// y_adder : ripple-carry adder with combinational sum and registered result
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module y_adder
  import y_pkg::*;
#(
  parameter int WIDTH = Y_WIDTH
) (
  output logic [WIDTH-1:0] z,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] z_q,
  output logic             cout_q,
  output logic             ovf_q
);
  wire [WIDTH:0] w_c;
  wire           w_ovf_d;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    yAdder1 u_fa (
      .z    (z[i]),
      .cout (w_c[i+1]),
      .a    (a[i]),
      .b    (b[i]),
      .cin  (w_c[i])
    );
  end

  assign cout = w_c[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out of it
  assign w_ovf_d = w_c[WIDTH] ^ w_c[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      z_q    <= z;
      cout_q <= cout;
      ovf_q  <= w_ovf_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_y_adder.sv
// ---------------------------------------------------------------------------
// tb_y_adder : randomized and directed self-checking bench for y_adder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_y_adder;
  import y_pkg::*;

  logic    clk;
  logic    rst;
  y_word_t a, b;
  logic    cin;
  y_word_t z, z_q;
  logic    cout, cout_q, ovf_q;

  int checks   = 0;
  int failures = 0;
  bit running  = 0;

  y_word_t m_zq;
  logic    m_cq, m_oq;

  y_adder #(.WIDTH(Y_WIDTH)) dut (
    .z(z), .cout(cout), .a(a), .b(b), .cin(cin),
    .clk(clk), .rst(rst), .z_q(z_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [32:0] sum_of(input y_word_t x, input y_word_t y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {32'd0, ci};
  endfunction

  function automatic logic ovf_of(input y_word_t x, input y_word_t y, input logic ci);
    logic [32:0] s;
    s = sum_of(x, y, ci);
    return (x[31] == y[31]) && (s[31] != x[31]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected registered state: last sampled inputs, or zero while in reset
  always @(posedge clk or posedge rst) begin
    logic [32:0] s;
    if (rst) begin
      m_zq = '0; m_cq = 1'b0; m_oq = 1'b0;
    end else begin
      s = sum_of(a, b, cin);
      m_zq = s[31:0]; m_cq = s[32]; m_oq = ovf_of(a, b, cin);
    end
  end

  always @(negedge clk) begin
    logic [32:0] s;
    if (running) begin
      s = sum_of(a, b, cin);
      chk("cyc_z",      {32'd0, z},      {32'd0, s[31:0]});
      chk("cyc_cout",   {63'd0, cout},   {63'd0, s[32]});
      chk("cyc_z_q",    {32'd0, z_q},    {32'd0, m_zq});
      chk("cyc_cout_q", {63'd0, cout_q}, {63'd0, m_cq});
      chk("cyc_ovf_q",  {63'd0, ovf_q},  {63'd0, m_oq});
    end
  end

  task automatic drive(input y_word_t x, input y_word_t y, input logic ci);
    @(posedge clk);
    #1;
    a = x; b = y; cin = ci;
    #1;
  endtask

  initial begin
    logic [32:0] s;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;
    #2;
    chk("rst_z_q",    {32'd0, z_q},    64'd0);
    chk("rst_cout_q", {63'd0, cout_q}, 64'd0);
    chk("rst_ovf_q",  {63'd0, ovf_q},  64'd0);
    #10;
    rst = 1'b0;
    running = 1'b1;

    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 12; i++) begin
        drive($urandom, $urandom, pass[0]);
        s = sum_of(a, b, cin);
        chk("rand_z",    {32'd0, z},    {32'd0, s[31:0]});
        chk("rand_cout", {63'd0, cout}, {63'd0, s[32]});
      end
    end

    drive(32'hFFFF_FFFF, 32'h0, 1'b1);
    chk("ripple_z",    {32'd0, z},    64'd0);
    chk("ripple_cout", {63'd0, cout}, 64'd1);
    @(posedge clk); #1;
    chk("ripple_ovf_q", {63'd0, ovf_q}, 64'd0);

    drive(32'h7FFF_FFFF, 32'h1, 1'b0);
    chk("povf_z",    {32'd0, z},    64'h8000_0000);
    chk("povf_cout", {63'd0, cout}, 64'd0);
    @(posedge clk); #1;
    chk("povf_ovf_q", {63'd0, ovf_q}, 64'd1);
    chk("povf_z_q",   {32'd0, z_q},   64'h8000_0000);

    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("novf_z",    {32'd0, z},    64'd0);
    chk("novf_cout", {63'd0, cout}, 64'd1);
    @(posedge clk); #1;
    chk("novf_ovf_q",  {63'd0, ovf_q},  64'd1);
    chk("novf_cout_q", {63'd0, cout_q}, 64'd1);

    drive(32'd5, 32'd7, 1'b1);
    chk("reg_pre_z_q", {32'd0, z_q}, 64'd0);
    chk("reg_z",       {32'd0, z},   64'd13);
    @(posedge clk); #1;
    chk("reg_z_q",    {32'd0, z_q},    64'd13);
    chk("reg_cout_q", {63'd0, cout_q}, 64'd0);

    #2;
    rst = 1'b1;
    #1;
    chk("arst_z_q",    {32'd0, z_q},    64'd0);
    chk("arst_cout_q", {63'd0, cout_q}, 64'd0);
    chk("arst_ovf_q",  {63'd0, ovf_q},  64'd0);
    chk("arst_z",      {32'd0, z},      64'd13);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold_z_q", {32'd0, z_q}, 64'd0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_rel_z_q", {32'd0, z_q}, 64'd13);

    drive(32'd0, 32'd0, 1'b0);
    chk("zero_z",    {32'd0, z},    64'd0);
    chk("zero_cout", {63'd0, cout}, 64'd0);
    drive(32'd0, 32'd0, 1'b1);
    chk("zero_ci_z",    {32'd0, z},    64'd1);
    chk("zero_ci_cout", {63'd0, cout}, 64'd0);

    repeat (2) @(posedge clk);
    #1;
    running = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/y_adder.md
# y_adder

32-bit ripple-carry adder with carry-in and carry-out, used as the integer add datapath of the lab CPU/ALU. The sum is available combinationally the same timestep the operands settle. A registered copy of the result (sum, carry, signed overflow) is captured every clock for downstream pipeline stages. The datapath is built from a chain of 1-bit full adders.

## Interface
Parameters:
- `WIDTH`, default 32, operand and result width in bits. Must be ≥ 2.

Ports:
- `clk`  input  1  single clock; all registered outputs update on the rising edge.
- `rst`  input  1  asynchronous, active-high reset; clears all registered outputs.
- `z`  output  WIDTH  combinational sum `a + b + cin`, low WIDTH bits.
- `cout`  output  1  combinational carry out of the MSB.
- `a`  input  WIDTH  operand A.
- `b`  input  WIDTH  operand B.
- `cin`  input  1  carry into bit 0.
- `z_q`  output  WIDTH  registered `z`.
- `cout_q`  output  1  registered `cout`.
- `ovf_q`  output  1  registered two's-complement overflow.

Positional order of the first five ports is fixed as `z, cout, a, b, cin`, so existing instantiations keep working. Registered ports follow: `clk, rst, z_q, cout_q, ovf_q`.

## Operation
- Sum: `{cout, z} = a + b + cin`, computed modulo 2^(WIDTH+1) and treated as unsigned.
- Carry chain:
  - `c[0] = cin`
  - Bit i: `z[i] = a[i] ^ b[i] ^ c[i]`
  - `c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]`
  - `cout = c[WIDTH]`
- Overflow: `ovf = c[WIDTH] ^ c[WIDTH-1]`. It is 1 when the operand signs match and the result sign differs.
- The combinational outputs `z` and `cout` contain no state. They are independent of `clk` and `rst`, including while reset is asserted.
- Registers: on each rising edge of `clk` with `rst` low, capture `z_q<=z`, `cout_q<=cout`, `ovf_q<=ovf`.
- Inputs are never X-masked. An X or Z on any input bit propagates to the affected outputs.

## Timing
- `z` and `cout` have zero-cycle latency. They must be settled within one simulation time unit of an input change (zero-delay gates).
- `z_q`, `cout_q` and `ovf_q` have 1-cycle latency and reflect the inputs sampled at the last rising edge.
- Reset values: `z_q = 0`, `cout_q = 0`, `ovf_q = 0`.
  - Asserting `rst` clears the registers immediately, without waiting for a clock edge.
  - While `rst` is high, clock edges are ignored.
  - The first edge after deassertion captures the current inputs normally.
- Reset mid-stream: the in-flight registered result is discarded. Combinational outputs keep tracking the inputs.
- Boundary: an all-ones operand plus carry wraps to zero with `cout = 1`. Full carry propagation runs from bit 0 to bit WIDTH-1 with no lookahead.

## Structure
- Sub-module `yAdder1` (1-bit full adder):
  - Ports in order: `z, cout, a, b, cin`.
  - Built from gate primitives (xor/and/or).
- `y_adder` instantiates WIDTH copies of `yAdder1` with a generate loop, chaining `cout[i]` to `cin[i+1]`.
- The behavioural `+` operator is not used in the datapath.
- Shared package `y_pkg`:
  - Constant `Y_WIDTH = 32`.
  - Typedef `y_word_t` as a `logic [Y_WIDTH-1:0]` word.
- No other constants are needed.

## Test plan
- Random sweep: 10+ random `a`/`b` pairs with `cin=0`, then the same with `cin=1`. After #1, `z` must equal the `===` model `a+b+cin` (low 32 bits), and `cout` must equal bit 32 of that sum.
- Full carry ripple: `a=32'hFFFF_FFFF`, `b=0`, `cin=1` gives `z=0`, `cout=1`, `ovf=0`.
- Signed overflow:
  - `a=32'h7FFF_FFFF`, `b=1`, `cin=0` gives `z=32'h8000_0000`, `cout=0`, and `ovf_q=1` after the next edge.
  - `a=b=32'h8000_0000` gives `z=0`, `cout=1`, `ovf_q=1`.
- Registered path: apply `a=5`, `b=7`, `cin=1`. Before the edge `z_q` holds its old value. After one rising edge `z_q=13`, `cout_q=0`.
- Async reset: with `z_q` nonzero, raise `rst` between clock edges.
  - `z_q`, `cout_q`, `ovf_q` go to 0 immediately.
  - `z` still equals `a+b+cin`.
  - They stay 0 across edges while `rst=1` and capture on the first edge after release.
- Zero case: `a=b=0`, `cin=0` gives `z=0`, `cout=0`. With `cin=1`, `z=1`, `cout=0`.
